// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART RX frame sequencer and the RX datapath.
// master = the sequencer, slave = the pin plus the sampler/checker blocks.
interface uart_rx_fsm_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                 RX_IN;
  logic [5:0]           PRESCALE;
  logic                 PAR_EN;
  logic                 strt_glitch;
  logic                 par_err;
  logic                 stp_err;
  logic [5:0]           edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 dat_samp_en;
  logic                 strt_chk_en;
  logic                 deser_en;
  logic                 par_chk_en;
  logic                 stp_chk_en;
  logic                 data_valid;

  modport master (
    input  RX_IN, PRESCALE, PAR_EN, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid
  );

  modport slave (
    output RX_IN, PRESCALE, PAR_EN, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detection, per-bit edge/data-bit counting,
// datapath enables and the one-cycle data_valid qualification pulse.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_fsm_if.master bus
);
  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [5:0]           edge_nxt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic                 wrap;
  logic                 dv_nxt;

  // Next state and counters; every transition inside a bit period waits for the wrap.
  always_comb begin
    state_nxt = state;
    edge_nxt  = bus.edge_cnt;
    bit_nxt   = bus.bit_cnt;
    wrap      = (bus.edge_cnt == (bus.PRESCALE - 6'd1));
    dv_nxt    = 1'b0;

    if (state inside {START, DATA, PARITY, STOP}) begin
      edge_nxt = wrap ? 6'd0 : (bus.edge_cnt + 6'd1);
    end

    case (state)
      IDLE: begin
        edge_nxt = 6'd0;
        bit_nxt  = '0;
        if (!bus.RX_IN) begin
          state_nxt = START;
          edge_nxt  = 6'd1;
        end
      end
      START: begin
        if (wrap) begin
          state_nxt = bus.strt_glitch ? IDLE : DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          if (bus.bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            state_nxt = bus.PAR_EN ? PARITY : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bus.bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (wrap) state_nxt = STOP;
      end
      STOP: begin
        if (wrap) state_nxt = ERR_CHK;
      end
      ERR_CHK: begin
        // Checker results are settled here; a low line is treated as the next start bit.
        dv_nxt  = !bus.stp_err && (!bus.PAR_EN || !bus.par_err);
        bit_nxt = '0;
        if (!bus.RX_IN) begin
          state_nxt = START;
          edge_nxt  = 6'd1;
        end else begin
          state_nxt = IDLE;
          edge_nxt  = 6'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        edge_nxt  = 6'd0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Enables are decoded from the next state so the registered copies track the state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state           <= IDLE;
      bus.edge_cnt    <= 6'd0;
      bus.bit_cnt     <= '0;
      bus.dat_samp_en <= 1'b0;
      bus.strt_chk_en <= 1'b0;
      bus.deser_en    <= 1'b0;
      bus.par_chk_en  <= 1'b0;
      bus.stp_chk_en  <= 1'b0;
      bus.data_valid  <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.edge_cnt    <= edge_nxt;
      bus.bit_cnt     <= bit_nxt;
      bus.dat_samp_en <= (state_nxt inside {START, DATA, PARITY, STOP});
      bus.strt_chk_en <= (state_nxt == START);
      bus.deser_en    <= (state_nxt == DATA);
      bus.par_chk_en  <= (state_nxt == PARITY);
      bus.stp_chk_en  <= (state_nxt == STOP);
      bus.data_valid  <= dv_nxt;
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: whole-frame cycle-by-cycle checks of counters,
// enables and data_valid for several prescale/parity/error/reset scenarios.
module tb_uart_rx_fsm;
  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // {edge_cnt, bit_cnt, samp, strt, deser, par, stp, data_valid}
  function automatic logic [14:0] obs();
    return {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
            bus.deser_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid};
  endfunction

  function automatic logic [14:0] mk(input int e, input int b, input logic [4:0] en, input logic dv);
    return {6'(e), 3'(b), en, dv};
  endfunction

  task automatic check(input string tag, input int v, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s v=%0d: observed %0h expected %0h", tag, v, got, exp);
    end
  endtask

  task automatic tick(input logic rx);
    bus.RX_IN = rx;
    @(posedge CLK);
    #1;
  endtask

  // One frame; v is the edge index after t0 whose sampled values are observed.
  task automatic frame(input int pre, input bit pen, input logic [7:0] d, input bit perr,
                       input bit serr, input bit started, input bit b2b, input string tag);
    logic [15:0] fb;
    logic [14:0] exp;
    int len, v, idx, ndeser, npar, c0;
    bit good;
    fb = 16'hFFFF;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
    if (pen) fb[9] = ^d;
    len  = (2 + 8 + int'(pen)) * pre;
    good = !serr && !(pen && perr);
    bus.PRESCALE = 6'(pre);
    bus.PAR_EN = pen;
    bus.par_err = perr;
    bus.stp_err = serr;
    bus.strt_glitch = 1'b0;
    ndeser = 0;
    npar = 0;
    c0 = started ? 1 : 0;
    for (int c = c0; c <= len; c++) begin
      tick((c == len) ? !b2b : fb[c / pre]);
      v = c + 1;
      if (v < len) begin
        idx = v / pre;
        if (idx == 0)             exp = mk(v % pre, 0, 5'b11000, 1'b0);
        else if (idx <= 8)        exp = mk(v % pre, idx - 1, 5'b10100, 1'b0);
        else if (pen && idx == 9) exp = mk(v % pre, 0, 5'b10010, 1'b0);
        else                      exp = mk(v % pre, 0, 5'b10001, 1'b0);
      end else if (v == len) begin
        exp = mk(0, 0, 5'b00000, 1'b0);
      end else begin
        exp = b2b ? mk(1, 0, 5'b11000, good) : mk(0, 0, 5'b00000, good);
      end
      ndeser += int'(bus.deser_en);
      npar   += int'(bus.par_chk_en);
      check(tag, v, 32'(obs()), 32'(exp));
    end
    check({tag, "_deser_cycles"}, len, ndeser, 8 * pre);
    check({tag, "_par_cycles"}, len, npar, pen ? pre : 0);
    if (!b2b) begin
      tick(1'b1);
      check({tag, "_after"}, len + 2, 32'(obs()), 32'(mk(0, 0, 5'b00000, 1'b0)));
    end
  endtask

  initial begin
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    tick(1'b1);
    tick(1'b1);
    check("reset", 0, 32'(obs()), 32'h0);
    RST = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      tick(1'b1);
      check("idle_hold", i, 32'(obs()), 32'h0);
    end

    frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "p8_good");
    frame(16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "p16_parerr");
    frame(16, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, "p16_par_good");
    frame(8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, "p8_stperr");
    frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, "p8_b2b");

    // Start glitch: short low pulse rejected at the end of the start bit.
    bus.PRESCALE = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.strt_glitch = 1'b1;
    tick(1'b0);
    for (int v = 1; v <= 20; v++) begin
      if (v < 8) check("glitch", v, 32'(obs()), 32'(mk(v, 0, 5'b11000, 1'b0)));
      else       check("glitch", v, 32'(obs()), 32'h0);
      tick(1'b1);
    end
    bus.strt_glitch = 1'b0;

    // Reset in the middle of data bit 3 at PRESCALE=32, then a clean frame.
    bus.PRESCALE = 6'd32;
    bus.stp_err = 1'b0;
    tick(1'b0);
    for (int c = 1; c <= 129; c++) tick((c < 32) ? 1'b0 : 1'b1);
    check("rst_mid_pre", 130, 32'(obs()), 32'(mk(2, 3, 5'b10100, 1'b0)));
    RST = 1'b0;
    tick(1'b1);
    check("rst_mid", 131, 32'(obs()), 32'h0);
    RST = 1'b1;
    tick(1'b1);
    check("rst_mid_idle", 132, 32'(obs()), 32'h0);
    frame(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, "p32_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
